// File: rtl/pixel_avg_requester.sv
// Raster grayscale stream reducer (2x2 average) that then runs one start/done
// request to the forward-logic block and strobes the returned digit.
module pixel_avg_requester #(
  parameter int unsigned IMG_SIDE       = 28,
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned PIXELS_AVG_NR  = (IMG_SIDE / 2) * (IMG_SIDE / 2),
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pix_valid,
  input  logic [WIDTH-1:0]               pix_data,
  output logic                           pix_ready,
  output logic [PIXELS_AVG_NR*WIDTH-1:0] averaged_pixels,
  output logic                           nn_start,
  output logic                           nn_en,
  input  logic                           nn_done,
  input  logic [3:0]                     nn_digit,
  output logic [3:0]                     digit_out,
  output logic                           digit_valid,
  output logic                           timeout_err,
  output logic                           busy
);

  localparam int unsigned HALF  = IMG_SIDE / 2;
  localparam int unsigned CNT_W = $clog2(IMG_SIDE);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IDX_W = (PIXELS_AVG_NR > 1) ? $clog2(PIXELS_AVG_NR) : 1;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_START,
    S_WAIT_DONE,
    S_RESULT
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] col, row;
  logic [WIDTH-1:0] hold;
  logic [WIDTH:0]   linebuf [HALF];
  logic [WD_W-1:0]  wd;

  logic             accept;
  logic             col_last, row_last, last_pix;
  logic             wd_expired;
  logic [CNT_W-2:0] lb_idx;
  logic [IDX_W-1:0] avg_idx;
  logic [WIDTH+1:0] quad_sum;

  assign accept     = pix_valid && pix_ready;
  assign col_last   = (col == CNT_W'(IMG_SIDE - 1));
  assign row_last   = (row == CNT_W'(IMG_SIDE - 1));
  assign last_pix   = accept && col_last && row_last;
  assign wd_expired = (wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign lb_idx     = col[CNT_W-1:1];

  always_comb begin
    avg_idx  = IDX_W'((32'(row) >> 1) * HALF + (32'(col) >> 1));
    quad_sum = (WIDTH+2)'(linebuf[lb_idx]) + (WIDTH+2)'(hold) + (WIDTH+2)'(pix_data);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_COLLECT;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    pix_ready   = 1'b0;
    nn_start    = 1'b0;
    nn_en       = 1'b0;
    digit_valid = 1'b0;
    busy        = 1'b1;
    case (state)
      S_COLLECT: begin
        pix_ready = 1'b1;
        busy      = 1'b0;
        if (last_pix) state_next = S_START;
      end
      S_START: begin
        nn_start   = 1'b1;
        nn_en      = 1'b1;
        state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        nn_en = 1'b1;
        if (nn_done || wd_expired) state_next = S_RESULT;
      end
      S_RESULT: begin
        digit_valid = 1'b1;
        state_next  = S_COLLECT;
      end
      default: state_next = S_COLLECT;
    endcase
  end

  // pix_ready is only high in COLLECT, so averaged_pixels cannot change mid-request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col             <= '0;
      row             <= '0;
      hold            <= '0;
      averaged_pixels <= '0;
      for (int unsigned i = 0; i < HALF; i++) linebuf[i] <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + CNT_W'(1);
      end else begin
        col <= col + CNT_W'(1);
      end
      if (!col[0])
        hold <= pix_data;
      else if (!row[0])
        linebuf[lb_idx] <= (WIDTH+1)'(hold) + (WIDTH+1)'(pix_data);
      else
        averaged_pixels[avg_idx*WIDTH +: WIDTH] <= quad_sum[WIDTH+1:2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd          <= '0;
      digit_out   <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_START: wd <= '0;
        S_WAIT_DONE: begin
          if (nn_done) begin
            digit_out   <= nn_digit;
            timeout_err <= 1'b0;
          end else if (wd_expired) begin
            digit_out   <= 4'hF;
            timeout_err <= 1'b1;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_avg_requester.sv
// Randomized bench for pixel_avg_requester against an image-level average model.
module tb_pixel_avg_requester;

  localparam int SIDE = 28;
  localparam int W    = 8;
  localparam int HALF = SIDE / 2;
  localparam int NAVG = HALF * HALF;
  localparam int NPIX = SIDE * SIDE;
  localparam int TO   = 100;

  logic            clk = 1'b0;
  logic            reset;
  logic            pix_valid;
  logic [W-1:0]    pix_data;
  logic            pix_ready;
  logic [NAVG*W-1:0] averaged_pixels;
  logic            nn_start, nn_en, nn_done;
  logic [3:0]      nn_digit, digit_out;
  logic            digit_valid, timeout_err, busy;

  pixel_avg_requester #(
    .IMG_SIDE(SIDE),
    .WIDTH(W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .pix_ready(pix_ready),
    .averaged_pixels(averaged_pixels),
    .nn_start(nn_start),
    .nn_en(nn_en),
    .nn_done(nn_done),
    .nn_digit(nn_digit),
    .digit_out(digit_out),
    .digit_valid(digit_valid),
    .timeout_err(timeout_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         img [NPIX];
  logic [3:0] exp_digit;
  logic       exp_to;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_avg(input int k);
    int r, c;
    r = 2 * (k / HALF);
    c = 2 * (k % HALF);
    return (img[r*SIDE+c] + img[r*SIDE+c+1] + img[(r+1)*SIDE+c] + img[(r+1)*SIDE+c+1]) / 4;
  endfunction

  task automatic check_avg(input string tag);
    for (int k = 0; k < NAVG; k++)
      check($sformatf("%s[%0d]", tag, k), 32'(averaged_pixels[k*W +: W]), 32'(model_avg(k)));
  endtask

  task automatic rand_img();
    for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 255));
  endtask

  // mode 0: back-to-back, 1: every other cycle, 2: random gaps
  task automatic send_frame(input int mode, input int n, input bit poke);
    int i = 0;
    int cyc = 0;
    int start_seen = 0;
    int dv_seen = 0;
    bit give;
    while (i < n && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (nn_start) start_seen++;
      if (digit_valid) dv_seen++;
      case (mode)
        0:       give = 1'b1;
        1:       give = (cyc % 2) == 1;
        default: give = 1'($urandom_range(0, 1));
      endcase
      pix_valid = give;
      pix_data  = give ? W'(img[i]) : W'($urandom);
      nn_done   = poke && ($urandom_range(0, 3) == 0);
      nn_digit  = 4'($urandom);
      if (give && pix_ready) i++;
    end
    check("frame_accepts", 32'(i), 32'(n));
    check("frame_no_start", 32'(start_seen), 0);
    check("frame_no_dvalid", 32'(dv_seen), 0);
  endtask

  // pix_valid is held high throughout so any wrongly consumed pixel would skew the next frame
  task automatic request(input int delay, input logic [3:0] dig, input bit respond, input bit done_in_start);
    int  start_cnt = 0;
    int  wait_cnt = 0;
    bit  got = 0;
    int  ready_seen = 0;
    for (int j = 1; j <= 400; j++) begin
      @(negedge clk);
      if (j == 1) begin
        check("start_after_last", 32'(nn_start), 1);
        check("en_at_start", 32'(nn_en), 1);
        check("busy_at_start", 32'(busy), 1);
      end
      if (nn_start) start_cnt++;
      if (nn_en && !nn_start) wait_cnt++;
      if (digit_valid) begin
        got = 1;
        break;
      end
      if (pix_ready) ready_seen++;
      pix_valid = 1'b1;
      pix_data  = W'($urandom);
      nn_done   = 1'b0;
      nn_digit  = 4'($urandom);
      if (done_in_start && j == 1) begin
        nn_done  = 1'b1;
        nn_digit = dig + 4'd1;
      end
      if (respond && j == delay + 1) begin
        nn_done  = 1'b1;
        nn_digit = dig;
      end
    end
    nn_done = 1'b0;
    if (respond) begin
      exp_digit = dig;
      exp_to    = 1'b0;
    end else begin
      exp_digit = 4'hF;
      exp_to    = 1'b1;
    end
    check("result_seen", 32'(got), 1);
    check("start_pulses", 32'(start_cnt), 1);
    check("wait_cycles", 32'(wait_cnt), respond ? 32'(delay) : 32'(TO));
    check("ready_low_busy", 32'(ready_seen), 0);
    check("digit_out", 32'(digit_out), 32'(exp_digit));
    check("timeout_err", 32'(timeout_err), 32'(exp_to));
    check("en_off_result", 32'(nn_en), 0);
    @(negedge clk);
    check("dvalid_one_cycle", 32'(digit_valid), 0);
    check("ready_back", 32'(pix_ready), 1);
    check("busy_clear", 32'(busy), 0);
    check("digit_hold", 32'(digit_out), 32'(exp_digit));
    pix_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(pix_ready), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_start"}, 32'(nn_start), 0);
    check({tag, "_en"}, 32'(nn_en), 0);
    check({tag, "_dvalid"}, 32'(digit_valid), 0);
    check({tag, "_to"}, 32'(timeout_err), 0);
    check({tag, "_digit"}, 32'(digit_out), 0);
    check({tag, "_avg0"}, 32'(averaged_pixels == '0), 1);
  endtask

  initial begin
    reset     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
    nn_done   = 1'b0;
    nn_digit  = '0;
    exp_digit = '0;
    exp_to    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("post_rst");

    // flat mid-gray image
    for (int i = 0; i < NPIX; i++) img[i] = 8'h80;
    send_frame(0, NPIX, 1'b0);
    request(10, 4'd7, 1'b1, 1'b0);
    check_avg("flat");

    // alternating 2x2 blocks: truncation (6>>2) and no overflow (1020>>2)
    for (int k = 0; k < NAVG; k++) begin
      int r, c;
      r = 2 * (k / HALF);
      c = 2 * (k % HALF);
      if (k % 2 == 0) begin
        img[r*SIDE+c] = 0; img[r*SIDE+c+1] = 1; img[(r+1)*SIDE+c] = 2; img[(r+1)*SIDE+c+1] = 3;
      end else begin
        img[r*SIDE+c] = 255; img[r*SIDE+c+1] = 255; img[(r+1)*SIDE+c] = 255; img[(r+1)*SIDE+c+1] = 255;
      end
    end
    send_frame(0, NPIX, 1'b0);
    request(int'($urandom_range(1, 20)), 4'($urandom), 1'b1, 1'b0);
    check_avg("alt");
    check("alt_k0", 32'(averaged_pixels[0 +: W]), 32'h01);
    check("alt_k1", 32'(averaged_pixels[W +: W]), 32'hFF);

    // same random image with back-to-back, toggled and random-gap valids
    rand_img();
    for (int m = 0; m < 3; m++) begin
      send_frame(m, NPIX, 1'b0);
      request(int'($urandom_range(1, 30)), 4'($urandom), 1'b1, 1'b0);
      check_avg($sformatf("mode%0d", m));
    end

    // watchdog expiry, then a good request clears the error
    rand_img();
    send_frame(2, NPIX, 1'b0);
    request(0, 4'd0, 1'b0, 1'b0);
    check_avg("to_frame");
    check("to_sticky", 32'(timeout_err), 1);
    rand_img();
    send_frame(0, NPIX, 1'b0);
    check("to_still_set", 32'(timeout_err), 1);
    request(int'($urandom_range(1, 30)), 4'd5, 1'b1, 1'b0);
    check_avg("after_to");

    // reset partway through a frame
    rand_img();
    send_frame(0, 300, 1'b0);
    @(negedge clk);
    reset     = 1'b0;
    pix_valid = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    repeat (2) @(negedge clk);
    reset     = 1'b1;
    exp_digit = '0;
    exp_to    = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_rel");
    rand_img();
    send_frame(0, NPIX, 1'b0);
    request(int'($urandom_range(1, 30)), 4'($urandom), 1'b1, 1'b0);
    check_avg("fresh");

    // stray nn_done during COLLECT and START must be ignored
    rand_img();
    send_frame(2, NPIX, 1'b1);
    check("stray_digit_hold", 32'(digit_out), 32'(exp_digit));
    request(5, 4'd3, 1'b1, 1'b1);
    check_avg("stray");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/pixel_avg_requester.md
# pixel_avg_requester

Front end that feeds the forward-logic FSM. Accepts a raster-order grayscale image stream and reduces it 2×2 into `pixels_averaged_nr` averaged pixels on the `averaged_pixels` bus. It then acts as initiator of the start/done handshake toward the forward-logic block, and returns the predicted digit to the system as a one-cycle result strobe.

## Interface
- `IMG_SIDE`, 28, input image side length in pixels; must be even.
- `WIDTH`, 8, bits per input pixel and per averaged pixel.
- `PIXELS_AVG_NR`, (IMG_SIDE/2)², number of averaged pixels (196 at default).
- `TIMEOUT_CYCLES`, 65535, maximum cycles spent waiting for `nn_done`.

Ports:
- `clk` in 1: single clock; all logic is posedge.
- `reset` in 1: asynchronous, active-low reset.
- `pix_valid` in 1: `pix_data` is valid.
- `pix_data` in WIDTH: pixel value, raster order (row-major, row 0 first).
- `pix_ready` out 1: the block accepts a pixel on an edge where `pix_valid & pix_ready` is true.
- `averaged_pixels` out PIXELS_AVG_NR*WIDTH: averaged image; pixel k occupies `[k*WIDTH +: WIDTH]`.
- `nn_start` out 1: start pulse to the forward-logic block.
- `nn_en` out 1: enable to the forward-logic block.
- `nn_done` in 1: one-cycle completion strobe from the forward-logic block.
- `nn_digit` in 4: predicted digit; sampled only when `nn_done` is high.
- `digit_out` out 4: last result.
- `digit_valid` out 1: one-cycle strobe when `digit_out` updates.
- `timeout_err` out 1: high if the last request timed out; cleared on the next successful result.
- `busy` out 1: high in every state except COLLECT.

## Operation
- States:
  - COLLECT: `pix_ready` = 1.
  - START: `nn_start` = 1 and `nn_en` = 1.
  - WAIT_DONE: `nn_en` = 1.
  - RESULT: `digit_valid` = 1.
- All outputs are decoded from registered state or come directly from registers.
- Counters: `col` and `row`, each 0..IMG_SIDE-1. Both advance only on an accepted pixel; `col` wraps and increments `row`.
- Even column: `hold <= pix_data`.
- Even row, odd column: `linebuf[col/2] <= hold + pix_data` (WIDTH+1 bits). `linebuf` holds IMG_SIDE/2 entries.
- Odd row, odd column: sum = `linebuf[col/2] + hold + pix_data` (WIDTH+2 bits). Write `sum[WIDTH+1:2]` (truncating) to index k = (row/2)*(IMG_SIDE/2) + col/2.
- On acceptance of the last pixel (row and col both at IMG_SIDE-1), the counters reset to 0 and the state goes COLLECT→START.
- START→WAIT_DONE unconditionally. `nn_start` is exactly one cycle wide.
- In WAIT_DONE on an edge with `nn_done`=1: `digit_out <= nn_digit`, `timeout_err <= 0`, next state RESULT.
- In WAIT_DONE when the watchdog reaches TIMEOUT_CYCLES-1 without `nn_done`: `digit_out <= 4'hF`, `timeout_err <= 1`, next state RESULT.
- The watchdog is cleared in START.
- RESULT→COLLECT unconditionally.
- `averaged_pixels` is not modified outside COLLECT, so it is stable throughout each request.
- `nn_done` is ignored outside WAIT_DONE.
- `pix_valid` is ignored outside COLLECT; no pixel is consumed.
- Reset (asserted at any time, including mid-frame or mid-request):
  - state COLLECT;
  - counters, `hold`, `linebuf`, `averaged_pixels`, `digit_out`, watchdog all 0;
  - `nn_start`, `nn_en`, `digit_valid`, `timeout_err`, `busy` = 0;
  - `pix_ready` = 1.

## Timing
- Pixel throughput: one per cycle while `pix_valid` is held high. Gaps in `pix_valid` cause only a stall.
- An averaged pixel is written on the same edge that accepts its fourth source pixel.
- The last pixel is accepted at edge N:
  - `nn_start` is high during cycle N..N+1.
  - `nn_en` is high from N until the edge that leaves WAIT_DONE.
- `nn_done` sampled at edge M: `digit_valid` and the new `digit_out` are visible after edge M, and `digit_valid` is high for one cycle.
- `pix_ready` returns to 1 after edge M+1.
- Frame-in to result latency = IMG_SIDE² accept cycles + 1 + downstream latency + 1.

## Test plan
- All pixels 0x80; `nn_done` with `nn_digit`=7 asserted 10 cycles after `nn_start` → every averaged byte is 0x80; one `nn_start` pulse one cycle after the 784th accept; `digit_out`=7; `digit_valid` high for exactly one cycle; `timeout_err`=0.
- 2×2 blocks alternating {0,1,2,3} and {255,255,255,255} → averaged pixels alternate 0x01 (6>>2) and 0xFF (1020>>2), confirming truncation and no overflow.
- `pix_valid` toggling every other cycle → same `averaged_pixels` as the back-to-back case. `pix_valid` held high during WAIT_DONE/RESULT → `pix_ready`=0 and the pixel counter does not move.
- `nn_done` never asserted (TIMEOUT_CYCLES=100 in this bench) → exactly 100 cycles after START: `digit_out`=0xF, `timeout_err`=1, `digit_valid` pulse, return to COLLECT. The next good request clears `timeout_err`.
- Reset asserted after 300 pixels, then released → all outputs at reset values. A fresh 784-pixel frame then produces a correct image starting from index 0, with a single `nn_start`.
- `nn_done` pulsed during COLLECT and during START → ignored; `digit_out` and `digit_valid` are unchanged, and the request completes only on a `nn_done` that arrives during WAIT_DONE.
